// File: rtl/expander_ctrl.sv
// expander_ctrl
//   Command sequencer between the SPI slave byte interface and the expander
//   output port. Received bytes are parsed into write/read transactions on a
//   small register bank. Register 0 drives the 8-bit expander output, and
//   read-back bytes are handed to the SPI slave transmit path.
//
//   Command byte: bit7=1 write, bit7=0 read, bits[6:0] start address.
//   Following bytes are burst data (write) or dummy bytes (read). The address
//   auto-increments and wraps to 0 after the last register.
//
// Parameters
//   NUM_REGS  number of 8-bit registers (2..127), reg 0 drives o_out
//   TIMEOUT   max clk cycles allowed between bytes inside a transaction (>=1)
//
// Optional feature macro: STATUS_REG_EN
//   When defined, address 7'h7F is a read-only status register returning
//   {err, busy, 6'b0}. Reading it clears err one cycle after the tx_latch.
//
// Ports
//   i_clk       system clock, rising edge
//   i_rst_n     asynchronous active-low reset
//   i_ss        SPI slave select (active-low), already synchronised
//   i_rx_data   received byte, valid with i_rx_rdy
//   i_rx_rdy    one-cycle pulse per received byte
//   o_tx_data   byte for the SPI slave to shift out next
//   o_tx_latch  one-cycle pulse: SPI slave captures o_tx_data
//   o_out       register 0 contents (expander pins)
//   o_busy      high while in a write or read data phase
//   o_err       sticky error flag
module expander_ctrl #(
  parameter int NUM_REGS = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_ss,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_rdy,
  output logic [7:0] o_tx_data,
  output logic       o_tx_latch,
  output logic [7:0] o_out,
  output logic       o_busy,
  output logic       o_err
);

  localparam int         AW          = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int         TW          = $clog2(TIMEOUT + 1);
  localparam logic [6:0] LAST_ADDR   = 7'(NUM_REGS - 1);
  localparam logic [6:0] NREGS_ADDR  = 7'(NUM_REGS);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA} state_t;

  state_t        r_state, w_state_next;
  logic [7:0]    r_regs [NUM_REGS];
  logic [6:0]    r_addr, w_addr_next;
  logic [TW-1:0] r_timer, w_timer_next;
  logic [7:0]    r_tx_data, w_tx_data_next;
  logic          r_tx_latch, w_tx_latch_next;
  logic          r_err, w_err_next;
  logic          r_clr_pend, w_clr_pend_next;

  logic          w_wr_en;
  logic          w_busy;
  logic [6:0]    w_cmd_addr;
  logic [6:0]    w_addr_inc;
  logic          w_cmd_ok, w_addr_ok;
  logic          w_cmd_stat, w_addr_stat;
  logic [7:0]    w_cmd_rd, w_inc_rd;

  assign w_busy     = (r_state == S_WDATA) || (r_state == S_RDATA);
  assign w_cmd_addr = i_rx_data[6:0];
  // Any address at or past the last register (including out-of-range ones)
  // wraps the burst back to 0.
  assign w_addr_inc = (r_addr >= LAST_ADDR) ? 7'd0 : r_addr + 7'd1;
  assign w_cmd_ok   = (w_cmd_addr < NREGS_ADDR);
  assign w_addr_ok  = (r_addr < NREGS_ADDR);

`ifdef STATUS_REG_EN
  assign w_cmd_stat  = (w_cmd_addr == 7'h7F);
  assign w_addr_stat = (r_addr == 7'h7F);
`else
  assign w_cmd_stat  = 1'b0;
  assign w_addr_stat = 1'b0;
`endif

  // Read value for a read command address; status is sampled before the
  // read clears err.
  always_comb begin
    w_cmd_rd = 8'hFF;
    if (w_cmd_stat)
      w_cmd_rd = {r_err, w_busy, 6'b0};
    else if (w_cmd_ok)
      w_cmd_rd = r_regs[w_cmd_addr[AW-1:0]];
  end

  // The incremented address is always inside the register range.
  assign w_inc_rd = r_regs[w_addr_inc[AW-1:0]];

  always_comb begin
    w_state_next    = r_state;
    w_addr_next     = r_addr;
    w_timer_next    = '0;
    w_tx_data_next  = r_tx_data;
    w_tx_latch_next = 1'b0;
    w_err_next      = r_err;
    w_clr_pend_next = 1'b0;
    w_wr_en         = 1'b0;

    // Pending status-read clear; any error raised this cycle overrides it.
    if (r_clr_pend)
      w_err_next = 1'b0;

    if (i_ss) begin
      // Deselect wins over a byte arriving in the same cycle.
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_state_next = S_CMD;
        S_CMD: begin
          if (i_rx_rdy) begin
            w_addr_next = w_cmd_addr;
            if (i_rx_data[7]) begin
              w_state_next = S_WDATA;
            end else begin
              w_state_next    = S_RDATA;
              w_tx_data_next  = w_cmd_rd;
              w_tx_latch_next = 1'b1;
              if (w_cmd_stat)
                w_clr_pend_next = 1'b1;
              else if (!w_cmd_ok)
                w_err_next = 1'b1;
            end
          end
        end
        S_WDATA, S_RDATA: begin
          if (i_rx_rdy) begin
            w_addr_next = w_addr_inc;
            if (r_state == S_WDATA) begin
              if (w_addr_ok)
                w_wr_en = 1'b1;
              else if (!w_addr_stat)
                w_err_next = 1'b1;
            end else begin
              w_tx_data_next  = w_inc_rd;
              w_tx_latch_next = 1'b1;
            end
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            // Timer would reach TIMEOUT this edge: abort to command phase.
            w_err_next   = 1'b1;
            w_state_next = S_CMD;
          end else begin
            w_timer_next = r_timer + 1'b1;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_timer    <= '0;
      r_tx_data  <= '0;
      r_tx_latch <= 1'b0;
      r_err      <= 1'b0;
      r_clr_pend <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_addr     <= w_addr_next;
      r_timer    <= w_timer_next;
      r_tx_data  <= w_tx_data_next;
      r_tx_latch <= w_tx_latch_next;
      r_err      <= w_err_next;
      r_clr_pend <= w_clr_pend_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[r_addr[AW-1:0]] <= i_rx_data;
    end
  end

  assign o_tx_data  = r_tx_data;
  assign o_tx_latch = r_tx_latch;
  assign o_out      = r_regs[0];
  assign o_busy     = w_busy;
  assign o_err      = r_err;

endmodule
